multicycle_ctrl: RTL and testbench

//  Main sequencer for the multicycle RV32I core: Moore FSM that steps each instruction through

---
 rtl/multicycle_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main sequencer: a Moore FSM that walks each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath
// select and write strobe. Memory states stall on MemReady_i.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  input  logic       MemReady_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       IRWrite_o,
  output logic       MemWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [3:0] ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic       retire_o,
  output logic       illegal_o
);

  // FSM state encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_UPPER    = 4'd12;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLT   = 4'h5;
  localparam logic [3:0] ALU_SLTU  = 4'h6;
  localparam logic [3:0] ALU_SLL   = 4'h7;
  localparam logic [3:0] ALU_SRL   = 4'h8;
  localparam logic [3:0] ALU_SRA   = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;

  // Datapath select encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] A_PC       = 2'b00;
  localparam logic [1:0] A_OLDPC    = 2'b01;
  localparam logic [1:0] A_RS1      = 2'b10;
  localparam logic [1:0] B_RS2      = 2'b00;
  localparam logic [1:0] B_IMM      = 2'b01;
  localparam logic [1:0] B_FOUR     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  logic [3:0] state, state_nxt;
  logic       br_bad, br_taken;
  logic [3:0] alu_r, alu_i;
  ctrl_t      ctrl;

  // branch funct3 010/011 are not defined; taken condition from ALU flags
  always_comb begin
    br_bad   = (funct3_i[2:1] == 2'b01);
    br_taken = 1'b0;
    case (funct3_i)
      3'b000:  br_taken = zero_i;
      3'b001:  br_taken = ~zero_i;
      3'b100:  br_taken = lt_i;
      3'b101:  br_taken = ~lt_i;
      3'b110:  br_taken = ltu_i;
      3'b111:  br_taken = ~ltu_i;
      default: br_taken = 1'b0;
    endcase
  end

  // ALU decode; the immediate form never subtracts, only shifts look at funct7b5
  always_comb begin
    alu_r = ALU_ADD;
    case (funct3_i)
      3'b000:  alu_r = funct7b5_i ? ALU_SUB : ALU_ADD;
      3'b001:  alu_r = ALU_SLL;
      3'b010:  alu_r = ALU_SLT;
      3'b011:  alu_r = ALU_SLTU;
      3'b100:  alu_r = ALU_XOR;
      3'b101:  alu_r = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  alu_r = ALU_OR;
      default: alu_r = ALU_AND;
    endcase
    alu_i = (funct3_i == 3'b000) ? ALU_ADD : alu_r;
  end

  // immediate format select follows the opcode directly
  always_comb begin
    case (op_i)
      OP_LOAD, OP_I, OP_JALR: ImmSrc_o = 3'b000;
      OP_STORE:               ImmSrc_o = 3'b001;
      OP_BRANCH:              ImmSrc_o = 3'b010;
      OP_JAL:                 ImmSrc_o = 3'b011;
      OP_LUI, OP_AUIPC:       ImmSrc_o = 3'b100;
      default:                ImmSrc_o = 3'b000;
    endcase
  end

  // next-state logic; memory states wait for MemReady_i
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = MemReady_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXECR;
          OP_I:              state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = br_bad ? S_FETCH : S_BRANCH;
          OP_JAL:            state_nxt = S_JUMP;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI, OP_AUIPC:  state_nxt = S_UPPER;
          default:           state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = MemReady_i ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = MemReady_i ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JALR:     state_nxt = S_JUMP;
      S_JUMP:     state_nxt = S_ALUWB;
      S_UPPER:    state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // state register; reset abandons whatever instruction was in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // per-state control word; anything not set stays 0 / ADD / select 00
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_a  = A_PC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.result_src = RES_ALURES;
        ctrl.ir_write   = MemReady_i;
        ctrl.pc_write   = MemReady_i;
      end
      S_DECODE: begin
        ctrl.alu_src_a = A_OLDPC;
        ctrl.alu_src_b = B_IMM;
        case (op_i)
          OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR,
          OP_LUI, OP_AUIPC: ctrl.illegal = 1'b0;
          OP_BRANCH:        ctrl.illegal = br_bad;
          default:          ctrl.illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
        ctrl.retire     = MemReady_i;
      end
      S_EXECR: begin
        ctrl.alu_src_a   = A_RS1;
        ctrl.alu_src_b   = B_RS2;
        ctrl.alu_control = alu_r;
      end
      S_EXECI: begin
        ctrl.alu_src_a   = A_RS1;
        ctrl.alu_src_b   = B_IMM;
        ctrl.alu_control = alu_i;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = A_RS1;
        ctrl.alu_src_b   = B_RS2;
        ctrl.alu_control = ALU_SUB;
        ctrl.result_src  = RES_ALUOUT;
        ctrl.pc_write    = br_taken;
        ctrl.retire      = 1'b1;
      end
      S_JALR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
      end
      S_JUMP: begin
        ctrl.alu_src_a  = A_OLDPC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      S_UPPER: begin
        ctrl.alu_src_b = B_IMM;
        if (op_i == OP_LUI) begin
          ctrl.alu_control = ALU_PASSB;
        end else begin
          ctrl.alu_src_a = A_OLDPC;
        end
      end
      default: ctrl = '0;
    endcase
  end

  // drive ports; strobes and pulses are suppressed for the whole reset cycle
  always_comb begin
    PCWrite_o    = ctrl.pc_write  & ~rst_i;
    IRWrite_o    = ctrl.ir_write  & ~rst_i;
    MemWrite_o   = ctrl.mem_write & ~rst_i;
    RegWrite_o   = ctrl.reg_write & ~rst_i;
    retire_o     = ctrl.retire    & ~rst_i;
    illegal_o    = ctrl.illegal   & ~rst_i;
    AdrSrc_o     = ctrl.adr_src;
    ResultSrc_o  = ctrl.result_src;
    ALUSrcA_o    = ctrl.alu_src_a;
    ALUSrcB_o    = ctrl.alu_src_b;
    ALUControl_o = ctrl.alu_control;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: every cycle's expected control word
// is queued with its stimulus and compared half a cycle later.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst, f7, zero, lt, ltu, ready;
  logic [6:0] op;
  logic [2:0] f3;
  logic       pcw, adr, irw, mw, rw, ret, ill;
  logic [1:0] rs, sa, sb_sel;
  logic [3:0] alu;
  logic [2:0] imm;

  int n_tot = 0;
  int n_pass = 0;
  logic [2:0]  cur_imm;
  logic [19:0] sb[$];
  logic        rq[$];
  logic        xq[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
    .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .MemReady_i(ready),
    .PCWrite_o(pcw), .AdrSrc_o(adr), .IRWrite_o(irw), .MemWrite_o(mw),
    .RegWrite_o(rw), .ResultSrc_o(rs), .ALUSrcA_o(sa), .ALUSrcB_o(sb_sel),
    .ALUControl_o(alu), .ImmSrc_o(imm), .retire_o(ret), .illegal_o(ill)
  );

  wire [19:0] obs = {pcw, adr, irw, mw, rw, rs, sa, sb_sel, alu, imm, ret, ill};

  // immediate format expected for an opcode
  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [19:0] ev(input logic p, a, i, m, r, input logic [1:0] res,
                                     input logic [1:0] xa, xb, input logic [3:0] c,
                                     input logic t, l);
    return {p, a, i, m, r, res, xa, xb, c, cur_imm, t, l};
  endfunction

  // expected control words per state, straight from the state table
  function automatic logic [19:0] s_fetch(input logic r);
    return ev(r, 0, r, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0, 0, 0); endfunction
  function automatic logic [19:0] s_decode(input logic l);
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0, 0, l); endfunction
  function automatic logic [19:0] s_memadr();
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0, 0, 0); endfunction
  function automatic logic [19:0] s_memread();
    return ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0); endfunction
  function automatic logic [19:0] s_memwb();
    return ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'h0, 1, 0); endfunction
  function automatic logic [19:0] s_memwrite(input logic r);
    return ev(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'h0, r, 0); endfunction
  function automatic logic [19:0] s_exec(input logic imm_b, input logic [3:0] c);
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b10, {1'b0, imm_b}, c, 0, 0); endfunction
  function automatic logic [19:0] s_aluwb();
    return ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0, 1, 0); endfunction
  function automatic logic [19:0] s_branch(input logic t);
    return ev(t, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h1, 1, 0); endfunction
  function automatic logic [19:0] s_jump(input logic live);
    return ev(live, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'h0, 0, 0); endfunction
  function automatic logic [19:0] s_upper(input logic lui);
    return ev(0, 0, 0, 0, 0, 2'b00, lui ? 2'b00 : 2'b01, 2'b01, lui ? 4'hA : 4'h0, 0, 0);
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic b);
    op = o; f3 = f; f7 = b; cur_imm = imm_of(o);
  endtask

  // queue one cycle: expected word, MemReady_i and rst_i for that cycle
  task automatic exp_cyc(input logic [19:0] v, input logic r, input logic x);
    sb.push_back(v); rq.push_back(r); xq.push_back(x);
  endtask

  task automatic test_reset();
    logic [19:0] got; int c = 0;
    set_instr(7'b1111111, 3'b000, 1'b0);
    repeat (2) exp_cyc(ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'h0, 0, 0), 1, 1);
    while (sb.size() > 0) begin
      ready = rq.pop_front(); rst = xq.pop_front();
      @(negedge clk); got = sb.pop_front(); n_tot++;
      if (obs !== got) $display("FAIL reset c%0d obs=%05h exp=%05h", c, obs, got);
      else n_pass++;
      c++; @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    logic [19:0] got; int c = 0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0);
    exp_cyc(s_exec(0, 4'h0), 1, 0); exp_cyc(s_aluwb(), 1, 0);
    while (sb.size() > 0) begin
      ready = rq.pop_front(); rst = xq.pop_front();
      @(negedge clk); got = sb.pop_front(); n_tot++;
      if (obs !== got) $display("FAIL add c%0d obs=%05h exp=%05h", c, obs, got);
      else n_pass++;
      c++; @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_variants();
    logic [19:0] got;
    logic [6:0] ops[7] = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h33, 7'h33, 7'h13};
    logic [2:0] fs[7]  = '{3'b000, 3'b101, 3'b101, 3'b000, 3'b011, 3'b111, 3'b010};
    logic       bs[7]  = '{1, 1, 1, 1, 0, 0, 0};
    logic [3:0] al[7]  = '{4'h1, 4'h9, 4'h9, 4'h0, 4'h6, 4'h2, 4'h5};
    for (int k = 0; k < 7; k++) begin
      int c = 0;
      set_instr(ops[k], fs[k], bs[k]);
      exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0);
      exp_cyc(s_exec(ops[k] == 7'h13, al[k]), 1, 0); exp_cyc(s_aluwb(), 1, 0);
      while (sb.size() > 0) begin
        ready = rq.pop_front(); rst = xq.pop_front();
        @(negedge clk); got = sb.pop_front(); n_tot++;
        if (obs !== got) $display("FAIL alu%0d c%0d obs=%05h exp=%05h", k, c, obs, got);
        else n_pass++;
        c++; @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_load_stall();
    logic [19:0] got; int c = 0;
    set_instr(7'b0000011, 3'b010, 1'b0);
    exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0); exp_cyc(s_memadr(), 1, 0);
    repeat (3) exp_cyc(s_memread(), 0, 0);
    exp_cyc(s_memread(), 1, 0); exp_cyc(s_memwb(), 1, 0);
    while (sb.size() > 0) begin
      ready = rq.pop_front(); rst = xq.pop_front();
      @(negedge clk); got = sb.pop_front(); n_tot++;
      if (obs !== got) $display("FAIL lw c%0d obs=%05h exp=%05h", c, obs, got);
      else n_pass++;
      c++; @(posedge clk); #1;
    end
  endtask

  task automatic test_store_stall();
    logic [19:0] got; int c = 0;
    set_instr(7'b0100011, 3'b010, 1'b0);
    exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0); exp_cyc(s_memadr(), 1, 0);
    exp_cyc(s_memwrite(0), 0, 0); exp_cyc(s_memwrite(0), 0, 0); exp_cyc(s_memwrite(1), 1, 0);
    while (sb.size() > 0) begin
      ready = rq.pop_front(); rst = xq.pop_front();
      @(negedge clk); got = sb.pop_front(); n_tot++;
      if (obs !== got) $display("FAIL sw c%0d obs=%05h exp=%05h", c, obs, got);
      else n_pass++;
      c++; @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_stall_lui();
    logic [19:0] got; int c = 0;
    set_instr(7'b0110111, 3'b000, 1'b0);
    exp_cyc(s_fetch(0), 0, 0); exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0);
    exp_cyc(s_upper(1), 1, 0); exp_cyc(s_aluwb(), 1, 0);
    while (sb.size() > 0) begin
      ready = rq.pop_front(); rst = xq.pop_front();
      @(negedge clk); got = sb.pop_front(); n_tot++;
      if (obs !== got) $display("FAIL lui c%0d obs=%05h exp=%05h", c, obs, got);
      else n_pass++;
      c++; @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [19:0] got;
    logic [2:0] fs[6] = '{3'b001, 3'b001, 3'b110, 3'b110, 3'b000, 3'b101};
    logic       zs[6] = '{1, 0, 0, 1, 1, 0};
    logic       ls[6] = '{0, 0, 1, 0, 0, 1};
    logic       us[6] = '{0, 0, 1, 0, 0, 1};
    logic       tk[6] = '{0, 1, 1, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      int c = 0;
      set_instr(7'b1100011, fs[k], 1'b0);
      zero = zs[k]; lt = ls[k]; ltu = us[k];
      if (k == 2) lt = 1'b0;
      exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0); exp_cyc(s_branch(tk[k]), 1, 0);
      while (sb.size() > 0) begin
        ready = rq.pop_front(); rst = xq.pop_front();
        @(negedge clk); got = sb.pop_front(); n_tot++;
        if (obs !== got) $display("FAIL br%0d c%0d obs=%05h exp=%05h", k, c, obs, got);
        else n_pass++;
        c++; @(posedge clk); #1;
      end
    end
    zero = 0; lt = 0; ltu = 0;
  endtask

  task automatic test_illegal();
    logic [19:0] got;
    logic [6:0] ops[2] = '{7'b1100011, 7'b1111111};
    logic [2:0] fs[2]  = '{3'b010, 3'b000};
    for (int k = 0; k < 2; k++) begin
      int c = 0;
      set_instr(ops[k], fs[k], 1'b0);
      exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(1), 1, 0); exp_cyc(s_fetch(0), 0, 0);
      while (sb.size() > 0) begin
        ready = rq.pop_front(); rst = xq.pop_front();
        @(negedge clk); got = sb.pop_front(); n_tot++;
        if (obs !== got) $display("FAIL ill%0d c%0d obs=%05h exp=%05h", k, c, obs, got);
        else n_pass++;
        c++; @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jumps();
    logic [19:0] got; int c = 0;
    set_instr(7'b1101111, 3'b000, 1'b0);
    exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0);
    exp_cyc(s_jump(1), 1, 0); exp_cyc(s_aluwb(), 1, 0);
    while (sb.size() > 0) begin
      ready = rq.pop_front(); rst = xq.pop_front();
      @(negedge clk); got = sb.pop_front(); n_tot++;
      if (obs !== got) $display("FAIL jal c%0d obs=%05h exp=%05h", c, obs, got);
      else n_pass++;
      c++; @(posedge clk); #1;
    end
    c = 0;
    set_instr(7'b0010111, 3'b000, 1'b0);
    exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0);
    exp_cyc(s_upper(0), 1, 0); exp_cyc(s_aluwb(), 1, 0);
    while (sb.size() > 0) begin
      ready = rq.pop_front(); rst = xq.pop_front();
      @(negedge clk); got = sb.pop_front(); n_tot++;
      if (obs !== got) $display("FAIL auipc c%0d obs=%05h exp=%05h", c, obs, got);
      else n_pass++;
      c++; @(posedge clk); #1;
    end
  endtask

  task automatic test_jalr_reset();
    logic [19:0] got; int c = 0;
    set_instr(7'b1100111, 3'b000, 1'b0);
    exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0); exp_cyc(s_memadr(), 1, 0);
    exp_cyc(s_jump(0), 1, 1);
    exp_cyc(s_fetch(1), 1, 0); exp_cyc(s_decode(0), 1, 0); exp_cyc(s_memadr(), 1, 0);
    exp_cyc(s_jump(1), 1, 0); exp_cyc(s_aluwb(), 1, 0);
    while (sb.size() > 0) begin
      ready = rq.pop_front(); rst = xq.pop_front();
      @(negedge clk); got = sb.pop_front(); n_tot++;
      if (obs !== got) $display("FAIL jalr c%0d obs=%05h exp=%05h", c, obs, got);
      else n_pass++;
      c++; @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1; ready = 1; zero = 0; lt = 0; ltu = 0;
    set_instr(7'b1111111, 3'b000, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_alu_variants();
    test_load_stall();
    test_store_stall();
    test_fetch_stall_lui();
    test_branch();
    test_illegal();
    test_jumps();
    test_jalr_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
